counter_config_sequencer: RTL
=============================

COUNTER_CONFIG_SEQUENCER -- requirements
Module: counter_config_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd4096, SHALL set the maximum WAIT-state dwell in clock cycles before a timeout is declared.
REQ-002 clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_in  input  1  synchronous, active-low reset, sampled on the rising edge of clk_in.
REQ-004 cfg_valid_in  input  1  request to program and start the counter.
REQ-005 cfg_ready_out  output  1  high only in IDLE; a request is accepted on a clock edge where cfg_valid_in and cfg_ready_out are both high.
REQ-006 plr_in, ulr_in, llr_in, ccr_in  input  8 each  preload, upper limit, lower limit and cycle count, captured on accept.
REQ-007 Dout  output  8  data bus to the up/down counter Din.
REQ-008 ncs_out, nwr_out, nrd_out  output  1 each  active-low chip select, write strobe and read strobe to the counter.
REQ-009 A0_out, A1_out  output  1 each  register select: PLR=00, ULR=01, LLR=10, CCR=11 as {A0,A1}.
REQ-010 start_out  output  1  one-cycle start pulse to the counter start_in.
REQ-011 err_in, ec_in  input  1 each  counter err_out and ec_out.
REQ-012 busy_out  output  1  high in every state except IDLE.
REQ-013 done_out  output  1  one-cycle completion pulse.
REQ-014 status_out  output  2  00 ok, 01 local range error, 10 counter error, 11 timeout; valid from done_out and held until the next accept.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 nrd_out SHALL be held at 1 at all times.
REQ-017 States: IDLE, CHECK, SETUP, STROBE, HOLD, START, WAIT, DONE.
REQ-018 IDLE -> CHECK on accept; the four inputs SHALL be latched into internal registers and status_out cleared to 00.
REQ-019 CHECK: if llr>ulr, plr<llr or plr>ulr, go to DONE with status 01 and perform no bus cycle; otherwise go to SETUP with register index 0.
REQ-020 Write order: ULR, LLR, PLR, CCR (index 0..3).
REQ-021 SETUP: ncs_out=0, nwr_out=1, and Dout/A0_out/A1_out driven for the current index.
REQ-022 STROBE: nwr_out=0, with address and data unchanged.
REQ-023 HOLD: nwr_out=1, with address and data unchanged; then go to SETUP with the next index, or to START after index 3.
REQ-024 START: start_out=1 for exactly one cycle with ncs_out=0; then go to WAIT.
REQ-025 ncs_out SHALL return to 1 in WAIT.
REQ-026 Timing: accept at edge 0 gives CHECK in cycle 1, the four write cycles in cycles 2-13 (3 cycles each), START in cycle 14 and WAIT from cycle 15.
REQ-027 WAIT: ec_in and err_in SHALL be edge-detected (0->1) against a one-cycle registered copy; levels already high on entry SHALL be ignored.
REQ-028 WAIT: an err_in rise SHALL give status 10, and an ec_in rise SHALL give status 00, each -> DONE; if both rise in the same cycle, err_in wins.
REQ-029 WAIT: a 16-bit counter SHALL clear on WAIT entry and increment each WAIT cycle; on reaching TIMEOUT_CYCLES without an event -> DONE with status 11.
REQ-030 The timeout counter SHALL saturate and SHALL not wrap.
REQ-031 DONE: done_out=1 for one cycle, then -> IDLE.
REQ-032 cfg_valid_in while busy SHALL be ignored; it SHALL not be queued.
REQ-033 Input changes on plr_in/ulr_in/llr_in/ccr_in after accept SHALL not affect the bus data.
REQ-034 ccr_in=0 SHALL be legal; the counter's ec_in response SHALL complete the request normally.

Reset
REQ-035 While reset_in=0 at a clock edge, the block SHALL enter IDLE with ncs_out=nwr_out=nrd_out=1, start_out=0, Dout=0, A0_out=A1_out=0, cfg_ready_out=1, busy_out=0, done_out=0, status_out=00, and the edge-detect and timeout registers at 0.
REQ-036 A reset mid-write SHALL deassert ncs_out and nwr_out on that edge; no partial register sequence SHALL resume after reset.

Verification
REQ-037 plr=20, ulr=50, llr=10, ccr=2 accepted -> write cycles in the order ULR 50 (01), LLR 10 (10), PLR 20 (00), CCR 2 (11), each with nwr_out low for exactly 1 cycle; start_out pulse in cycle 14.
REQ-038 plr=5, llr=10, ulr=50 -> no ncs_out assertion, done_out in cycle 2, status 01.
REQ-039 Valid config, ec_in rises 30 cycles after START -> done_out and status 00; ec_in high on WAIT entry with no later rise -> timeout status 11 after TIMEOUT_CYCLES (bench parameter 64).
REQ-040 err_in and ec_in rise in the same WAIT cycle -> status 10.
REQ-041 reset_in driven low during the STROBE of the LLR write -> next edge ncs_out=1, nwr_out=1, cfg_ready_out=1; a new request then restarts from the ULR write.
REQ-042 cfg_valid_in held high through an entire run -> exactly one accept per IDLE visit, and inputs changed mid-run do not appear on Dout.

Source files
------------

// File: rtl/counter_config_sequencer.sv
// ----------------------------------------------------------------------------
// counter_config_sequencer
//
// Purpose:
//   Programs an external up/down counter over a small parallel bus and then
//   supervises its run.
//
//   Sequence for one request:
//     1. Accept the configuration.
//     2. Range-check it locally.
//     3. Write ULR, LLR, PLR and CCR in that order. Each write is a
//        three-cycle setup/strobe/hold bus cycle.
//     4. Pulse start_out.
//     5. Wait for the counter to report end-of-count or an error, or time out.
//     6. Pulse done_out with a status code.
//
// Ports:
//   clk_in         single rising-edge clock
//   reset_in       synchronous active-low reset
//   cfg_valid_in   request to program and start the counter
//   cfg_ready_out  high only while idle; accept = cfg_valid_in & cfg_ready_out
//   plr_in/ulr_in/llr_in/ccr_in
//                  preload, upper limit, lower limit, cycle count (8 bits each)
//   Dout           data bus to the counter
//   ncs_out        active-low chip select to the counter
//   nwr_out        active-low write strobe to the counter
//   nrd_out        active-low read strobe to the counter (never asserted)
//   A0_out, A1_out register select: PLR=00, ULR=01, LLR=10, CCR=11 as {A0,A1}
//   start_out      one-cycle start pulse to the counter
//   err_in, ec_in  counter error and end-of-count outputs
//   busy_out       high in every state except idle
//   done_out       one-cycle completion pulse
//   status_out     00 ok, 01 range error, 10 counter error, 11 timeout
// ----------------------------------------------------------------------------
module counter_config_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       cfg_valid_in,
    output logic       cfg_ready_out,
    input  logic [7:0] plr_in,
    input  logic [7:0] ulr_in,
    input  logic [7:0] llr_in,
    input  logic [7:0] ccr_in,
    output logic [7:0] Dout,
    output logic       ncs_out,
    output logic       nwr_out,
    output logic       nrd_out,
    output logic       A0_out,
    output logic       A1_out,
    output logic       start_out,
    input  logic       err_in,
    input  logic       ec_in,
    output logic       busy_out,
    output logic       done_out,
    output logic [1:0] status_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d, ccr_q, ccr_d;
    logic [15:0] timer_q, timer_d;
    logic        err_prev_q, err_prev_d, ec_prev_q, ec_prev_d;

    logic [7:0]  dout_q, dout_d;
    logic        ncs_q, ncs_d, nwr_q, nwr_d, nrd_q, nrd_d;
    logic        a0_q, a0_d, a1_q, a1_d;
    logic        start_q, start_d, ready_q, ready_d, busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  status_q, status_d;

    logic        err_rise, ec_rise;
    logic [15:0] timer_inc;
    logic        write_phase;

    // Rising edges are judged against the previous cycle's level. A level
    // that is already high when WAIT is entered therefore never counts.
    assign err_rise  = err_in & ~err_prev_q;
    assign ec_rise   = ec_in & ~ec_prev_q;
    assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

    // Next-state logic. The outputs are decoded from the *next* state so that
    // the registered outputs line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        plr_d      = plr_q;
        ulr_d      = ulr_q;
        llr_d      = llr_q;
        ccr_d      = ccr_q;
        timer_d    = timer_q;
        status_d   = status_q;
        err_prev_d = err_in;
        ec_prev_d  = ec_in;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid_in && ready_q) begin
                    plr_d    = plr_in;
                    ulr_d    = ulr_in;
                    llr_d    = llr_in;
                    ccr_d    = ccr_in;
                    status_d = 2'b00;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((llr_q > ulr_q) || (plr_q < llr_q) || (plr_q > ulr_q)) begin
                    status_d = 2'b01;
                    state_d  = S_DONE;
                end else begin
                    idx_d   = 2'd0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                if (idx_q == 2'd3) begin
                    state_d = S_START;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_SETUP;
                end
            end
            S_START: begin
                timer_d = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_inc;
                // An error wins over end-of-count when both rise together.
                if (err_rise) begin
                    status_d = 2'b10;
                    state_d  = S_DONE;
                end else if (ec_rise) begin
                    status_d = 2'b00;
                    state_d  = S_DONE;
                end else if (timer_inc >= TIMEOUT_CYCLES) begin
                    status_d = 2'b11;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        write_phase = (state_d == S_SETUP) || (state_d == S_STROBE) ||
                      (state_d == S_HOLD);

        // Write order is ULR, LLR, PLR, CCR for index 0..3.
        dout_d = 8'd0;
        a0_d   = 1'b0;
        a1_d   = 1'b0;
        if (write_phase) begin
            case (idx_d)
                2'd0: begin dout_d = ulr_d; a0_d = 1'b0; a1_d = 1'b1; end
                2'd1: begin dout_d = llr_d; a0_d = 1'b1; a1_d = 1'b0; end
                2'd2: begin dout_d = plr_d; a0_d = 1'b0; a1_d = 1'b0; end
                default: begin dout_d = ccr_d; a0_d = 1'b1; a1_d = 1'b1; end
            endcase
        end

        ncs_d   = ~(write_phase || (state_d == S_START));
        nwr_d   = ~(state_d == S_STROBE);
        nrd_d   = 1'b1;
        start_d = (state_d == S_START);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // Single state/output register. Reset wins on any edge, which also
    // aborts a bus cycle in progress without resuming it afterwards.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            plr_q      <= 8'd0;
            ulr_q      <= 8'd0;
            llr_q      <= 8'd0;
            ccr_q      <= 8'd0;
            timer_q    <= 16'd0;
            err_prev_q <= 1'b0;
            ec_prev_q  <= 1'b0;
            dout_q     <= 8'd0;
            ncs_q      <= 1'b1;
            nwr_q      <= 1'b1;
            nrd_q      <= 1'b1;
            a0_q       <= 1'b0;
            a1_q       <= 1'b0;
            start_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            plr_q      <= plr_d;
            ulr_q      <= ulr_d;
            llr_q      <= llr_d;
            ccr_q      <= ccr_d;
            timer_q    <= timer_d;
            err_prev_q <= err_prev_d;
            ec_prev_q  <= ec_prev_d;
            dout_q     <= dout_d;
            ncs_q      <= ncs_d;
            nwr_q      <= nwr_d;
            nrd_q      <= nrd_d;
            a0_q       <= a0_d;
            a1_q       <= a1_d;
            start_q    <= start_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            status_q   <= status_d;
        end
    end

    assign Dout          = dout_q;
    assign ncs_out       = ncs_q;
    assign nwr_out       = nwr_q;
    assign nrd_out       = nrd_q;
    assign A0_out        = a0_q;
    assign A1_out        = a1_q;
    assign start_out     = start_q;
    assign cfg_ready_out = ready_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign status_out    = status_q;

endmodule
